// File: rtl/lwe_sample_extract_pkg.sv
// Shared constants for LWE sample extraction; MODSWITCH_EN selects the q-width (Q->q) output build.
package lwe_sample_extract_pkg;
   localparam int RING_DEPTH = 10;
   localparam int N          = 1 << RING_DEPTH;
   localparam int IDX_W      = RING_DEPTH + 1;
   localparam int DATA_W     = 27;
   localparam int unsigned Q = 132120577;
   localparam int QW         = 9;
   localparam int RD_LAT     = 1;
   localparam int MS_LAT     = 3;
   localparam int FIFO_DEPTH = RD_LAT + MS_LAT + 2;

   localparam logic [DATA_W-1:0] Q_VAL  = DATA_W'(Q);
   localparam logic [DATA_W-1:0] Q_HALF = DATA_W'(Q >> 1);

   // Rounding numerator x*2^QW + floor(Q/2) stays below 2^MS_SHIFT, so a floor reciprocal at that
   // shift underestimates the quotient by at most one.
   localparam int MS_NUM_W   = DATA_W + QW + 1;
   localparam int MS_SHIFT   = MS_NUM_W;
   localparam int MS_RECIP_W = QW + 2;
   localparam logic [MS_RECIP_W-1:0] MS_RECIP = MS_RECIP_W'((64'd1 << MS_SHIFT) / 64'(Q));

`ifdef MODSWITCH_EN
   localparam int OUT_W = QW;
`else
   localparam int OUT_W = DATA_W;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;
endpackage

// File: rtl/lwe_mod_switch.sv
// Pipelined Q -> 2^QW rounding: y = floor((x*2^QW + floor(Q/2)) / Q) mod 2^QW, latency MS_LAT.
module lwe_mod_switch
   import lwe_sample_extract_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] x,
   output logic [QW-1:0]     y
);
   localparam int PROD_W = MS_NUM_W + MS_RECIP_W;
   localparam int QUO_W  = QW + 1;

   logic [MS_NUM_W-1:0] num_s1, num_s2, rem_s2;
   logic [QUO_W-1:0]    quo_s2;

   assign rem_s2 = num_s2 - MS_NUM_W'(quo_s2) * MS_NUM_W'(Q);

   always_ff @(posedge clk) begin
      if (reset) begin
         num_s1 <= '0;
         num_s2 <= '0;
         quo_s2 <= '0;
         y      <= '0;
      end else begin
         num_s1 <= MS_NUM_W'({x, {QW{1'b0}}}) + MS_NUM_W'(Q_HALF);
         num_s2 <= num_s1;
         quo_s2 <= QUO_W'((PROD_W'(num_s1) * PROD_W'(MS_RECIP)) >> MS_SHIFT);
         // estimate is exact or one low; quotient 2^QW wraps to 0 in the truncation
         y      <= (rem_s2 >= MS_NUM_W'(Q)) ? QW'(quo_s2 + 1'b1) : QW'(quo_s2);
      end
   end
endmodule

// File: rtl/lwe_sample_extract.sv
// Reads the RLWE accumulator, extracts the LWE sample (reordered/negated mask, body b_0) and streams
// it through a credit-protected FIFO; MODSWITCH_EN inserts the Q->q modulus switch.
module lwe_sample_extract
   import lwe_sample_extract_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  acc_read_addr,
   input  logic [DATA_W-1:0] acc_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last
);
   // state    | meaning
   // ST_IDLE  | waiting for start
   // ST_ISSUE | issuing the N+1 accumulator reads, one per cycle while credit allows
   // ST_DRAIN | all reads issued, waiting for the body word to be accepted
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  iss_cnt, iss_addr;
   logic [CNT_W-1:0]  inflight, fifo_cnt;
   logic [CNT_W:0]    occ;
   logic              credit, issue, push, pop, last_pop, done_r;
   logic [RD_LAT:0]   rd_v;
   logic [IDX_W-1:0]  rd_idx [RD_LAT+1];
   logic [IDX_W-1:0]  ext_idx;
   logic [DATA_W-1:0] ext_data;
   logic [OUT_W-1:0]  push_data;
   logic [IDX_W-1:0]  push_idx;
   logic [OUT_W-1:0]  fifo_data [FIFO_DEPTH];
   logic [IDX_W-1:0]  fifo_idx  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   assign pop      = out_valid & out_ready;
   assign last_pop = pop & (fifo_idx[rd_ptr] == IDX_W'(N));
   // The slot freed by a pop in this cycle counts as available, so a pipeline as long as the
   // FIFO is deep still sustains one word per cycle.
   assign occ      = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_cnt) - (CNT_W+1)'(pop);
   assign credit   = occ < (CNT_W+1)'(FIFO_DEPTH);
   assign iss_addr = (iss_cnt == '0 || iss_cnt == IDX_W'(N)) ? iss_cnt : IDX_W'(N) - iss_cnt;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_ISSUE;
         ST_ISSUE: if (credit) begin
            issue = 1'b1;
            if (iss_cnt == IDX_W'(N)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (last_pop) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign ext_idx = rd_idx[RD_LAT];
   always_comb begin
      ext_data = acc_read_data;
      if (ext_idx != '0 && ext_idx != IDX_W'(N) && acc_read_data != '0)
         ext_data = Q_VAL - acc_read_data;
   end

`ifdef MODSWITCH_EN
   logic [MS_LAT-1:0] ms_v;
   logic [IDX_W-1:0]  ms_idx [MS_LAT];

   lwe_mod_switch u_mod_switch (.clk(clk), .reset(reset), .x(ext_data), .y(push_data));

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_v <= '0;
         for (int k = 0; k < MS_LAT; k++) ms_idx[k] <= '0;
      end else begin
         ms_v      <= {ms_v[MS_LAT-2:0], rd_v[RD_LAT]};
         ms_idx[0] <= ext_idx;
         for (int k = 1; k < MS_LAT; k++) ms_idx[k] <= ms_idx[k-1];
      end
   end

   assign push     = ms_v[MS_LAT-1];
   assign push_idx = ms_idx[MS_LAT-1];
`else
   assign push      = rd_v[RD_LAT];
   assign push_data = ext_data;
   assign push_idx  = ext_idx;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         iss_cnt       <= '0;
         acc_read_addr <= '0;
         rd_v          <= '0;
         inflight      <= '0;
         fifo_cnt      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         done_r        <= 1'b0;
         for (int k = 0; k <= RD_LAT; k++) rd_idx[k] <= '0;
      end else begin
         if (issue) begin
            acc_read_addr <= iss_addr;
            iss_cnt       <= (iss_cnt == IDX_W'(N)) ? '0 : iss_cnt + 1'b1;
         end
         rd_v      <= {rd_v[RD_LAT-1:0], issue};
         rd_idx[0] <= iss_cnt;
         for (int k = 1; k <= RD_LAT; k++) rd_idx[k] <= rd_idx[k-1];
         inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         done_r <= last_pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_idx[wr_ptr]  <= push_idx;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = done_r;
   assign out_valid = (fifo_cnt != '0);
   assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_index = out_valid ? fifo_idx[rd_ptr] : '0;
   assign out_last  = out_valid && (fifo_idx[rd_ptr] == IDX_W'(N));
endmodule

// File: tb/tb_lwe_sample_extract.sv
// Directed bench for lwe_sample_extract: ordering, extraction values, backpressure, reset and start abuse.
module tb_lwe_sample_extract;
   import lwe_sample_extract_pkg::*;

`ifdef MODSWITCH_EN
   localparam int LAT = RD_LAT + MS_LAT + 2;
`else
   localparam int LAT = RD_LAT + 2;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, out_valid, out_last;
   logic              out_ready = 1'b0;
   logic [IDX_W-1:0]  acc_read_addr, out_index;
   logic [DATA_W-1:0] acc_read_data;
   logic [OUT_W-1:0]  out_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] mem [2*N];
   longint unsigned   got_data [N+1];
   int                got_idx  [N+1];
   bit                got_last [N+1];
   int                addr_log [N+2];
   int n_acc, first_valid_c, first_acc_c, last_acc_c, done_c, n_done, stab_err;

   lwe_sample_extract dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .acc_read_addr(acc_read_addr), .acc_read_data(acc_read_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) acc_read_data <= mem[acc_read_addr];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic longint unsigned exp_word(int i);
      longint unsigned x;
      if (i == 0)     x = longint'(mem[0]);
      else if (i < N) x = (mem[N-i] == '0) ? 64'd0 : longint'(Q) - longint'(mem[N-i]);
      else            x = longint'(mem[N]);
`ifdef MODSWITCH_EN
      x = (((x << QW) + longint'(Q / 2)) / longint'(Q)) % (64'd1 << QW);
`endif
      return x;
   endfunction

   function automatic int count_bad();
      int bad = 0;
      for (int i = 0; i <= N; i++)
         if (got_data[i] !== exp_word(i) || got_idx[i] !== i || got_last[i] !== (i == N)) bad++;
      return bad;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 2*N; i++) mem[i] = DATA_W'($urandom_range(0, Q - 1));
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < 2*N; i++) mem[i] = DATA_W'((i * 129061 + 17) % Q);
      mem[5] = '0;
   endtask

   // Starts a stream and collects it; c counts negedges after the edge that samples start.
   task automatic run_stream(input int pct, input int stop_words, input int restart_c);
      bit               stalled = 0;
      logic [OUT_W-1:0] hd = '0;
      logic [IDX_W-1:0] hi = '0;
      logic             hl = 1'b0;
      n_acc = 0; first_valid_c = -1; first_acc_c = -1; last_acc_c = -1;
      done_c = -1; n_done = 0; stab_err = 0;
      for (int i = 0; i <= N; i++) begin
         got_data[i] = '1; got_idx[i] = -1; got_last[i] = 1'b0;
      end
      for (int i = 0; i <= N + 1; i++) addr_log[i] = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         start = (c == restart_c);
         if (c <= N + 1) addr_log[c] = int'(acc_read_addr);
         if (done) begin
            n_done++;
            if (done_c < 0) done_c = c;
         end
         if (stalled && (!out_valid || out_data !== hd || out_index !== hi || out_last !== hl))
            stab_err++;
         if (out_valid && first_valid_c < 0) first_valid_c = c;
         if (done_c >= 0 && c >= done_c + 3) break;
         out_ready = ($urandom_range(0, 99) < pct);
         if (out_valid && out_ready) begin
            if (n_acc <= N) begin
               got_data[n_acc] = longint'(out_data);
               got_idx[n_acc]  = int'(out_index);
               got_last[n_acc] = out_last;
            end
            if (first_acc_c < 0) first_acc_c = c;
            last_acc_c = c;
            n_acc++;
         end
         stalled = out_valid && !out_ready;
         hd = out_data; hi = out_index; hl = out_last;
         if (stop_words > 0 && n_acc >= stop_words) break;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if ({busy, done, out_valid, out_last, out_index, out_data, acc_read_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_held: outputs %h, expected 0",
                  {busy, done, out_valid, out_last, out_index, out_data, acc_read_addr});
      end
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, done, out_valid, acc_read_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: outputs %h, expected 0", {busy, done, out_valid, acc_read_addr});
      end
   endtask

   task automatic test_address_order();
      int bad = 0;
      int exp_a;
      fill_pattern();
      run_stream(100, 0, -1);
      for (int k = 0; k <= N; k++) begin
         exp_a = (k == 0) ? 0 : (k < N) ? N - k : N;
         if (addr_log[k+1] !== exp_a) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL addr_order: %0d wrong addresses, expected 0 (addr[1]=%0d want 1023)",
                  bad, addr_log[2]);
      end
      n_tests++;
      if (first_valid_c !== LAT) begin
         n_fail++;
         $display("FAIL first_latency: got %0d expected %0d", first_valid_c, LAT);
      end
      n_tests++;
      if (n_acc !== N + 1) begin
         n_fail++;
         $display("FAIL order_count: got %0d expected %0d", n_acc, N + 1);
      end
      n_tests++;
      if (count_bad() !== 0) begin
         n_fail++;
         $display("FAIL order_data: %0d bad words, expected 0", count_bad());
      end
      n_tests++;
      if (done_c !== last_acc_c + 1 || n_done !== 1) begin
         n_fail++;
         $display("FAIL done_timing: done at %0d (count %0d), expected %0d (count 1)",
                  done_c, n_done, last_acc_c + 1);
      end
      n_tests++;
      if (last_acc_c - first_acc_c !== N) begin
         n_fail++;
         $display("FAIL throughput: span %0d, expected %0d", last_acc_c - first_acc_c, N);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_done: got %0b expected 0", busy);
      end
   endtask

   task automatic test_values();
`ifdef MODSWITCH_EN
      int unsigned a0_in  [3] = '{32'd16515072, 32'd66060288, 32'd1000};
      int unsigned a0_exp [3] = '{32'd64, 32'd256, 32'd0};
      fill_random();
      mem[N-1] = DATA_W'(1);
      mem[N]   = DATA_W'(33030144);
      for (int r = 0; r < 3; r++) begin
         mem[0] = DATA_W'(a0_in[r]);
         run_stream(100, 0, -1);
         n_tests++;
         if (got_data[0] !== longint'(a0_exp[r])) begin
            n_fail++;
            $display("FAIL ms_a0_%0d: got %0d expected %0d", r, got_data[0], a0_exp[r]);
         end
      end
      n_tests++;
      if (got_data[1] !== 64'd0) begin
         n_fail++;
         $display("FAIL ms_wrap: got %0d expected 0", got_data[1]);
      end
      n_tests++;
      if (got_data[N] !== 64'd128) begin
         n_fail++;
         $display("FAIL ms_body: got %0d expected 128", got_data[N]);
      end
`else
      fill_random();
      mem[0]   = DATA_W'(77);
      mem[N-1] = DATA_W'(1);
      mem[1]   = '0;
      mem[N]   = DATA_W'(5);
      run_stream(100, 0, -1);
      n_tests++;
      if (got_data[0] !== 64'd77) begin
         n_fail++;
         $display("FAIL ext_a0: got %0d expected 77", got_data[0]);
      end
      n_tests++;
      if (got_data[1] !== 64'd132120576) begin
         n_fail++;
         $display("FAIL ext_neg1: got %0d expected 132120576", got_data[1]);
      end
      n_tests++;
      if (got_data[N-1] !== 64'd0) begin
         n_fail++;
         $display("FAIL ext_zero: got %0d expected 0", got_data[N-1]);
      end
      n_tests++;
      if (got_data[N] !== 64'd5) begin
         n_fail++;
         $display("FAIL ext_body: got %0d expected 5", got_data[N]);
      end
`endif
   endtask

   task automatic test_backpressure();
      fill_random();
      run_stream(30, 0, -1);
      n_tests++;
      if (n_acc !== N + 1) begin
         n_fail++;
         $display("FAIL bp_count: got %0d expected %0d", n_acc, N + 1);
      end
      n_tests++;
      if (count_bad() !== 0) begin
         n_fail++;
         $display("FAIL bp_data: %0d bad words, expected 0", count_bad());
      end
      n_tests++;
      if (stab_err !== 0) begin
         n_fail++;
         $display("FAIL bp_stable: %0d changes while stalled, expected 0", stab_err);
      end
      n_tests++;
      if (n_done !== 1) begin
         n_fail++;
         $display("FAIL bp_done: got %0d pulses expected 1", n_done);
      end
   endtask

   task automatic test_sweep();
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_stream(100, 0, -1);
         n_tests++;
         if (count_bad() !== 0 || n_acc !== N + 1) begin
            n_fail++;
            $display("FAIL sweep_%0d: %0d bad words of %0d, expected 0 of %0d", r, count_bad(), n_acc, N + 1);
         end
         n_tests++;
         if (last_acc_c - first_acc_c !== N) begin
            n_fail++;
            $display("FAIL sweep_span_%0d: got %0d expected %0d", r, last_acc_c - first_acc_c, N);
         end
      end
   endtask

   task automatic test_reset_abort();
      int bad = 0;
      fill_random();
      run_stream(100, 500, -1);
      n_tests++;
      if (n_acc !== 500) begin
         n_fail++;
         $display("FAIL abort_reach: got %0d words expected 500", n_acc);
      end
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({busy, done, out_valid, out_last, out_index, out_data, acc_read_addr} !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: got %h expected 0",
                  {busy, done, out_valid, out_last, out_index, out_data, acc_read_addr});
      end
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || out_valid || busy) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL abort_quiet: %0d active cycles after reset, expected 0", bad);
      end
      fill_random();
      run_stream(100, 0, -1);
      n_tests++;
      if (count_bad() !== 0 || n_acc !== N + 1 || n_done !== 1) begin
         n_fail++;
         $display("FAIL abort_restart: bad %0d words %0d done %0d, expected 0/%0d/1",
                  count_bad(), n_acc, n_done, N + 1);
      end
   endtask

   task automatic test_start_abuse();
      fill_random();
      run_stream(100, 0, 300);
      n_tests++;
      if (count_bad() !== 0 || n_acc !== N + 1) begin
         n_fail++;
         $display("FAIL start_abuse_data: bad %0d words %0d, expected 0/%0d", count_bad(), n_acc, N + 1);
      end
      n_tests++;
      if (n_done !== 1 || done_c !== last_acc_c + 1) begin
         n_fail++;
         $display("FAIL start_abuse_done: count %0d at %0d, expected 1 at %0d", n_done, done_c, last_acc_c + 1);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_abuse_idle: busy %0b expected 0", busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 2*N; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_address_order();
      test_values();
      test_backpressure();
      test_sweep();
      test_reset_abort();
      test_start_abuse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
